// File: rtl/tx_combiner_core.sv
// Multi-channel gain/sum/scale combiner with saturation, a shadowed configuration
// that swaps in on peak-interval boundaries, and a per-interval peak detector.
module tx_combiner_core #(
  parameter int NUMBER_OF_LINE = 8,
  parameter int NUMBER_OF_ADC  = 3,
  parameter int GAIN_WIDTH     = 8
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic [16*NUMBER_OF_LINE*NUMBER_OF_ADC-1:0] adc_data,
  input  logic                                     adc_valid,
  input  logic [GAIN_WIDTH*NUMBER_OF_ADC-1:0]      channel_gain,
  input  logic [NUMBER_OF_ADC-1:0]                 channel_enable,
  input  logic [3:0]                               scale_select,
  input  logic [15:0]                              interval_length,
  input  logic                                     config_update,
  output logic [16*NUMBER_OF_LINE-1:0]             dac_data,
  output logic                                     dac_valid,
  output logic [15:0]                              interval_max,
  output logic                                     interval_valid,
  output logic [15:0]                              saturation_count
);

  localparam int PW = 17 + GAIN_WIDTH;
  localparam int SW = PW + $clog2(NUMBER_OF_ADC);
  localparam logic signed [SW-1:0] SAT_HI = SW'(32767);
  localparam logic signed [SW-1:0] SAT_LO = SW'(-32768);

  logic [GAIN_WIDTH*NUMBER_OF_ADC-1:0] shd_gain, act_gain;
  logic [NUMBER_OF_ADC-1:0]            shd_enable, act_enable;
  logic [3:0]                          shd_scale, act_scale;
  logic [15:0]                         shd_length, act_length;
  logic                                pending;
  logic                                boundary;
  logic                                apply_cfg;

  logic [16*NUMBER_OF_LINE*NUMBER_OF_ADC-1:0] s1_data;
  logic                                       s1_valid;
  logic signed [PW-1:0] s2_prod [NUMBER_OF_ADC][NUMBER_OF_LINE];
  logic                 s2_valid;
  logic signed [SW-1:0] lane_sum [NUMBER_OF_LINE];
  logic signed [SW-1:0] s3_sum [NUMBER_OF_LINE];
  logic                 s3_valid;
  logic [16*NUMBER_OF_LINE-1:0] lane_out;
  logic                         any_clip;

  logic [15:0] running_max, interval_count, cur_peak, peak_new;

  // Gain is zero-extended so the multiply stays signed without reinterpreting large gains.
  function automatic logic signed [PW-1:0] scale_mul(input logic signed [15:0] sample,
                                                     input logic [GAIN_WIDTH-1:0] gain);
    logic signed [PW-1:0] se;
    logic signed [PW-1:0] ge;
    se = PW'(sample);
    ge = PW'({1'b0, gain});
    return se * ge;
  endfunction

  // An update landing on a boundary is held pending, so only the older shadow is applied here.
  assign apply_cfg = pending && ((act_length == 16'd0) || boundary);

  always_ff @(posedge clock) begin
    if (reset) begin
      shd_gain   <= '0;
      shd_enable <= '0;
      shd_scale  <= '0;
      shd_length <= '0;
      act_gain   <= '0;
      act_enable <= '0;
      act_scale  <= '0;
      act_length <= '0;
      pending    <= 1'b0;
    end else begin
      if (apply_cfg) begin
        act_gain   <= shd_gain;
        act_enable <= shd_enable;
        act_scale  <= shd_scale;
        act_length <= shd_length;
      end
      if (config_update) begin
        shd_gain   <= channel_gain;
        shd_enable <= channel_enable;
        shd_scale  <= scale_select;
        shd_length <= interval_length;
        pending    <= 1'b1;
      end else if (apply_cfg) begin
        pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
      for (int c = 0; c < NUMBER_OF_ADC; c++)
        for (int l = 0; l < NUMBER_OF_LINE; l++)
          s2_prod[c][l] <= '0;
      for (int l = 0; l < NUMBER_OF_LINE; l++)
        s3_sum[l] <= '0;
    end else begin
      s1_data  <= adc_data;
      s1_valid <= adc_valid;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
      for (int c = 0; c < NUMBER_OF_ADC; c++)
        for (int l = 0; l < NUMBER_OF_LINE; l++)
          if (act_enable[c])
            s2_prod[c][l] <= scale_mul(s1_data[16*(c*NUMBER_OF_LINE+l) +: 16],
                                       act_gain[GAIN_WIDTH*c +: GAIN_WIDTH]);
          else
            s2_prod[c][l] <= '0;
      for (int l = 0; l < NUMBER_OF_LINE; l++)
        s3_sum[l] <= lane_sum[l];
    end
  end

  always_comb begin
    for (int l = 0; l < NUMBER_OF_LINE; l++) begin
      lane_sum[l] = '0;
      for (int c = 0; c < NUMBER_OF_ADC; c++)
        lane_sum[l] = lane_sum[l] + SW'(s2_prod[c][l]);
    end
  end

  always_comb begin
    logic signed [SW-1:0] shifted;
    lane_out = '0;
    any_clip = 1'b0;
    shifted  = '0;
    for (int l = 0; l < NUMBER_OF_LINE; l++) begin
      shifted = s3_sum[l] >>> act_scale;
      if (shifted > SAT_HI) begin
        lane_out[16*l +: 16] = 16'h7FFF;
        any_clip = 1'b1;
      end else if (shifted < SAT_LO) begin
        lane_out[16*l +: 16] = 16'h8000;
        any_clip = 1'b1;
      end else begin
        lane_out[16*l +: 16] = shifted[15:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dac_data         <= '0;
      dac_valid        <= 1'b0;
      saturation_count <= '0;
    end else begin
      dac_valid <= s3_valid;
      dac_data  <= s3_valid ? lane_out : '0;
      if (s3_valid && any_clip && (saturation_count != 16'hFFFF))
        saturation_count <= saturation_count + 16'd1;
    end
  end

  // Magnitude of -32768 is folded to 32767 so the peak always fits the positive range.
  always_comb begin
    logic [15:0] raw;
    logic [15:0] mag;
    cur_peak = '0;
    raw      = '0;
    mag      = '0;
    for (int l = 0; l < NUMBER_OF_LINE; l++) begin
      raw = dac_data[16*l +: 16];
      if (raw == 16'h8000)
        mag = 16'h7FFF;
      else if (raw[15])
        mag = ~raw + 16'd1;
      else
        mag = raw;
      if (mag > cur_peak)
        cur_peak = mag;
    end
    peak_new = (cur_peak > running_max) ? cur_peak : running_max;
  end

  assign boundary = dac_valid && (act_length != 16'd0) &&
                    (interval_count >= act_length - 16'd1);

  always_ff @(posedge clock) begin
    if (reset) begin
      running_max    <= '0;
      interval_count <= '0;
      interval_max   <= '0;
      interval_valid <= 1'b0;
    end else begin
      interval_valid <= 1'b0;
      if (dac_valid && (act_length != 16'd0)) begin
        if (boundary) begin
          interval_max   <= peak_new;
          interval_valid <= 1'b1;
          running_max    <= '0;
          interval_count <= '0;
        end else begin
          running_max    <= peak_new;
          interval_count <= interval_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: doc/tx_combiner_core.md
TX_COMBINER_CORE -- requirements
Module: tx_combiner_core

Interface
REQ-001 SHALL have parameter NUMBER_OF_LINE, default 8: 16-bit samples per clock per channel.
REQ-002 SHALL have parameter NUMBER_OF_ADC, default 3: number of input channels combined.
REQ-003 SHALL have parameter GAIN_WIDTH, default 8: unsigned per-channel gain width.
REQ-004 SHALL have one clock and a synchronous, active-high reset; all logic is clocked on the rising edge of clock.
REQ-005 SHALL have port clock, input, 1: sole clock.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port adc_data, input, 16*NUMBER_OF_LINE*NUMBER_OF_ADC: channel c lane l at bits 16*(c*NUMBER_OF_LINE+l) +: 16, signed.
REQ-008 SHALL have port adc_valid, input, 1: adc_data qualifier.
REQ-009 SHALL have port channel_gain, input, GAIN_WIDTH*NUMBER_OF_ADC: unsigned gain, channel c at GAIN_WIDTH*c +: GAIN_WIDTH.
REQ-010 SHALL have port channel_enable, input, NUMBER_OF_ADC: per-channel enable.
REQ-011 SHALL have port scale_select, input, 4: arithmetic right shift 0..15.
REQ-012 SHALL have port interval_length, input, 16: valid output cycles per peak interval; 0 = peak detector off.
REQ-013 SHALL have port config_update, input, 1: pulse capturing REQ-009..REQ-012 into a shadow copy.
REQ-014 SHALL have port dac_data, output, 16*NUMBER_OF_LINE: combined signed samples, lane l at 16*l +: 16.
REQ-015 SHALL have port dac_valid, output, 1: dac_data qualifier.
REQ-016 SHALL have port interval_max, output, 16: peak absolute value of the last completed interval.
REQ-017 SHALL have port interval_valid, output, 1: one-cycle pulse when interval_max updates.
REQ-018 SHALL have port saturation_count, output, 16: count of saturated valid output cycles.

Function
REQ-019 Pipeline SHALL be 4 stages: register inputs; form products sample*gain (gain zero-extended, full width); sum enabled products per lane with clog2(NUMBER_OF_ADC) guard bits; shift right arithmetically (truncate toward -inf) by scale_select, then saturate to [-32768, 32767].
REQ-020 dac_valid SHALL equal adc_valid delayed exactly 4 cycles, and the pipeline SHALL advance every cycle.
REQ-021 dac_data SHALL be 0 whenever dac_valid is 0.
REQ-022 Disabled channels SHALL contribute 0 regardless of gain.
REQ-023 config_update SHALL write the shadow copy and set a pending flag; a repeated update while pending SHALL overwrite the shadow, leaving one pending.
REQ-024 A pending shadow SHALL become active when either the active interval_length is 0 (the next cycle) or an interval boundary occurs (the cycle after the boundary), and the pending flag SHALL then clear.
REQ-025 A config_update coinciding with a boundary SHALL NOT apply at that boundary; it SHALL apply at the following boundary.
REQ-026 The active gain/enable SHALL govern stage-2 products and the active scale_select SHALL govern stage 4, from the cycle after activation; in-flight samples are not recomputed.
REQ-027 Peak detector, when active length N>0: for each valid output cycle, take the max over lanes of |dac_data| (|-32768| = 32767) and fold it into a running max; an interval counter counts valid cycles only.
REQ-028 When the counter reaches N-1 on a valid cycle (the boundary), the block SHALL register interval_max = max(running max, current), pulse interval_valid for 1 cycle, and zero the running max and counter.
REQ-029 If the counter is at or above a newly activated N, the next valid cycle SHALL be treated as a boundary.
REQ-030 saturation_count SHALL increment by 1 per valid output cycle in which any lane clipped, and SHALL stick at 0xFFFF.

Reset
REQ-031 Reset SHALL clear the pipeline, dac_data, dac_valid, interval_max, interval_valid, saturation_count, the counters, the running max and the pending flag, and SHALL set active/shadow gain 0, enable 0, scale 0 and length 0.
REQ-032 Reset asserted mid-stream SHALL force all outputs to 0 on the next cycle; data in flight is discarded.

Verification
REQ-033 Reset, then config_update with ch0 gain 128 enabled, others disabled, scale 7, length 4; drive continuous valid with all ch0 lanes = 1000 -> dac_data lanes = 1000, dac_valid 4 cycles after adc_valid.
REQ-034 All 3 channels enabled, gain 255, scale 0, samples 32767 -> lanes 32767 and saturation_count +1/cycle; with samples -32768 -> lanes -32768.
REQ-035 Length 4, unity config, lane0 sequence 5, -300, 20, 7 -> interval_max 300 with a single interval_valid pulse; with a sample of -32768 -> interval_max 32767.
REQ-036 Mid-interval config_update changing ch0 gain 128 -> 64 -> output unchanged until the cycle after interval_valid, then halved.
REQ-037 adc_valid gaps (1 valid, 2 invalid, repeated) with length 4 -> interval_valid only after 4 valid outputs, and dac_data 0 during gaps.
REQ-038 1-cycle reset mid-stream -> next cycle all outputs 0; the configuration reverts to 0 until a new config_update.
